// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor TX packer: FSM encoding,
// the line terminator, and the nibble-to-ASCII hex conversion.
package coproc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        TERM = 2'd2
    } state_e;

    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Uppercase hex digit: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/coprocessor_tx_packer_if.sv
// Word-in / byte-out bus of the TX packer. The coprocessor side and the
// UART side share one bundle; the packer is the slave.
interface coprocessor_tx_packer_if #(
    parameter int WIDTH_DOUT = 128
);
    logic [WIDTH_DOUT-1:0] word_in;
    logic                  word_valid;
    logic                  hex_mode;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  busy;
    logic                  overflow;
    logic                  overflow_clr;

    modport master (
        output word_in, word_valid, hex_mode, tx_ready, overflow_clr,
        input  tx_data, tx_valid, busy, overflow
    );

    modport slave (
        input  word_in, word_valid, hex_mode, tx_ready, overflow_clr,
        output tx_data, tx_valid, busy, overflow
    );
endinterface

// File: rtl/coprocessor_tx_packer.sv
// Serialises coprocessor result words into a UART byte stream, either as
// raw bytes (MSB first) or as uppercase ASCII hex followed by LF.
// One word is in flight in the shifter and one may wait in the pending buffer.
// All outputs are registered: tx_data is computed from the next-state shifter.
module coprocessor_tx_packer
    import coproc_pkg::*;
#(
    parameter int WIDTH_DOUT = 128,
    parameter int NUM_BYTES  = WIDTH_DOUT / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    coprocessor_tx_packer_if.slave  bus
);

    localparam int IDX_W = $clog2(2 * NUM_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_RAW = IDX_W'(NUM_BYTES - 1);
    localparam logic [IDX_W-1:0] LAST_HEX = IDX_W'(2 * NUM_BYTES - 1);

    state_e                r_state,  w_state;
    logic [WIDTH_DOUT-1:0] r_shift,  w_shift;
    logic [WIDTH_DOUT-1:0] r_pend,   w_pend;
    logic                  r_pend_v, w_pend_v;
    logic                  r_hex,    w_hex;
    logic [IDX_W-1:0]      r_idx,    w_idx;
    logic [7:0]            r_tx_data, w_char;
    logic                  r_tx_valid;
    logic                  r_busy;
    logic                  r_overflow;
    logic                  w_accept, w_last, w_done, w_drop;

    // Next-state, shifter, pending-buffer and drop decisions.
    always_comb begin
        w_state  = r_state;
        w_shift  = r_shift;
        w_pend   = r_pend;
        w_pend_v = r_pend_v;
        w_hex    = r_hex;
        w_idx    = r_idx;
        w_drop   = 1'b0;

        w_accept = r_tx_valid && bus.tx_ready;
        w_last   = (r_state == SEND) && (r_idx == (r_hex ? LAST_HEX : LAST_RAW));
        // Word finished: last raw byte, or the LF after a hex word.
        w_done   = w_accept && ((w_last && !r_hex) || (r_state == TERM));

        case (r_state)
            IDLE: begin
                if (bus.word_valid) begin
                    w_state = SEND;
                    w_shift = bus.word_in;
                    w_hex   = bus.hex_mode;
                    w_idx   = '0;
                end
            end
            SEND: begin
                if (w_accept) begin
                    w_shift = r_hex ? (r_shift << 4) : (r_shift << 8);
                    w_idx   = r_idx + IDX_W'(1);
                    if (w_last && r_hex) w_state = TERM;
                end
            end
            TERM: ;
            default: w_state = IDLE;
        endcase

        // Word boundary: pull the next word in on the same edge so the
        // byte stream has no bubble. A word arriving now refills pend.
        if (w_done) begin
            w_idx   = '0;
            w_hex   = bus.hex_mode;
            w_state = SEND;
            if (r_pend_v) begin
                w_shift  = r_pend;
                w_pend_v = bus.word_valid;
                if (bus.word_valid) w_pend = bus.word_in;
            end else if (bus.word_valid) begin
                w_shift = bus.word_in;
            end else begin
                w_state = IDLE;
            end
        end else if ((r_state != IDLE) && bus.word_valid) begin
            if (!r_pend_v) begin
                w_pend   = bus.word_in;
                w_pend_v = 1'b1;
            end else begin
                w_drop = 1'b1;
            end
        end
    end

    // Character that the next cycle will present.
    always_comb begin
        w_char = 8'h00;
        case (w_state)
            SEND:    w_char = w_hex ? nibble_to_ascii(w_shift[WIDTH_DOUT-1 -: 4])
                                    : w_shift[WIDTH_DOUT-1 -: 8];
            TERM:    w_char = ASCII_LF;
            default: w_char = 8'h00;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_pend     <= '0;
            r_pend_v   <= 1'b0;
            r_hex      <= 1'b0;
            r_idx      <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_shift    <= w_shift;
            r_pend     <= w_pend;
            r_pend_v   <= w_pend_v;
            r_hex      <= w_hex;
            r_idx      <= w_idx;
            r_tx_data  <= w_char;
            r_tx_valid <= (w_state != IDLE);
            r_busy     <= (w_state != IDLE) || w_pend_v;
            // A drop in the clear cycle wins so no loss goes unreported.
            r_overflow <= (r_overflow && !bus.overflow_clr) || w_drop;
        end
    end

    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = r_tx_valid;
    assign bus.busy     = r_busy;
    assign bus.overflow = r_overflow;

endmodule
